conv_host_mem: RTL and testbench

Host-side memory responder for the CONV accelerator: the other end of its `ready`/`busy`, image-read and layer-memory ports. It loads a 64x64 image from a host stream and starts the accelerator. It serves `iaddr`/`idata` reads, and serves `csel`-banked layer writes and reads during the run. When `busy` falls it flags completion and streams any selected result bank back to the host with valid/ready.

---
 rtl/conv_host_mem.sv | 227 ++++++++++++++++++++++
 tb/tb_conv_host_mem.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_host_mem.sv
`default_nettype none
// ============================================================================
// Module   : conv_host_mem
// Purpose  : Host-side image/layer memory responder for the CONV accelerator.
// Revision : 1.0 - initial release
// ============================================================================
module conv_host_mem #(
    parameter int DW        = 20,
    parameter int AW        = 12,
    parameter int IMG_DEPTH = 4096,
    parameter int L1_DEPTH  = 1024,
    parameter int L2_DEPTH  = 2048
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    input  logic          dump_req,
    input  logic [2:0]    dump_sel,
    output logic          dump_valid,
    output logic [DW-1:0] dump_data,
    output logic          dump_last,
    input  logic          dump_ready,
    output logic          done,
    output logic          err,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel
);

    localparam int            c_L1_AW    = $clog2(L1_DEPTH);
    localparam int            c_L2_AW    = $clog2(L2_DEPTH);
    localparam logic [AW:0]   c_IMG_D    = (AW+1)'(IMG_DEPTH);
    localparam logic [AW:0]   c_L1_D     = (AW+1)'(L1_DEPTH);
    localparam logic [AW:0]   c_L2_D     = (AW+1)'(L2_DEPTH);
    localparam logic [AW-1:0] c_IMG_LAST = AW'(IMG_DEPTH - 1);
    localparam logic [AW-1:0] c_L1_LAST  = AW'(L1_DEPTH - 1);
    localparam logic [AW-1:0] c_L2_LAST  = AW'(L2_DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_ARM       = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_RUN       = 3'd4,
        ST_DUMP      = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_load_cnt;
    logic [AW-1:0] r_ptr;
    logic [2:0]    r_dump_sel;
    logic [1:0]    r_wait_cnt;
    logic          r_busy_d;
    logic          r_err;

    logic [DW-1:0] r_img   [IMG_DEPTH];
    logic [DW-1:0] r_bank1 [IMG_DEPTH];
    logic [DW-1:0] r_bank2 [IMG_DEPTH];
    logic [DW-1:0] r_bank3 [L1_DEPTH];
    logic [DW-1:0] r_bank4 [L1_DEPTH];
    logic [DW-1:0] r_bank5 [L2_DEPTH];

    // Depth of a bank; zero for the "no bank" selections so range checks fail.
    function automatic logic [AW:0] bank_depth(input logic [2:0] sel);
        case (sel)
            3'd1, 3'd2: bank_depth = c_IMG_D;
            3'd3, 3'd4: bank_depth = c_L1_D;
            3'd5:       bank_depth = c_L2_D;
            default:    bank_depth = '0;
        endcase
    endfunction

    logic w_start_load, w_dump_sel_ok, w_start_dump, w_bad_dump;
    logic w_load_beat, w_load_done, w_timeout, w_busy_fall;
    logic w_dump_beat, w_dump_end, w_wr_active, w_wr_ok, w_wr_err, w_rd_ok;
    logic [AW-1:0] w_dump_last_idx;

    assign w_start_load  = (r_state == ST_IDLE) && load_start;
    assign w_dump_sel_ok = (dump_sel != 3'd0) && (dump_sel <= 3'd5);
    assign w_start_dump  = (r_state == ST_IDLE) && !load_start && dump_req && w_dump_sel_ok;
    assign w_bad_dump    = (r_state == ST_IDLE) && !load_start && dump_req && !w_dump_sel_ok;
    assign w_load_beat   = (r_state == ST_LOAD) && load_valid;
    assign w_load_done   = w_load_beat && (r_load_cnt == c_IMG_LAST);
    assign w_timeout     = (r_state == ST_WAIT_BUSY) && !busy && (r_wait_cnt == 2'd3);
    assign w_busy_fall   = r_busy_d && !busy;
    assign w_dump_beat   = (r_state == ST_DUMP) && dump_ready;
    assign w_dump_end    = w_dump_beat && (r_ptr == w_dump_last_idx);

    assign w_wr_active = cwr && ((r_state == ST_ARM) || (r_state == ST_WAIT_BUSY) ||
                                 (r_state == ST_RUN));
    assign w_wr_ok     = w_wr_active && ({1'b0, caddr_wr} < bank_depth(csel));
    assign w_wr_err    = w_wr_active && !({1'b0, caddr_wr} < bank_depth(csel));
    assign w_rd_ok     = crd && ({1'b0, caddr_rd} < bank_depth(csel));

    always_comb begin
        case (r_dump_sel)
            3'd3, 3'd4: w_dump_last_idx = c_L1_LAST;
            3'd5:       w_dump_last_idx = c_L2_LAST;
            default:    w_dump_last_idx = c_IMG_LAST;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_load)
                    w_next_state = ST_LOAD;
                else if (w_start_dump)
                    w_next_state = ST_DUMP;
            end
            ST_LOAD:      if (w_load_done) w_next_state = ST_ARM;
            ST_ARM:       w_next_state = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (busy)
                    w_next_state = ST_RUN;
                else if (w_timeout)
                    w_next_state = ST_IDLE;
            end
            ST_RUN:       if (w_busy_fall) w_next_state = ST_IDLE;
            ST_DUMP:      if (w_dump_end) w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_load_cnt <= '0;
            r_ptr      <= '0;
            r_dump_sel <= 3'd0;
            r_wait_cnt <= 2'd0;
            r_busy_d   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_busy_d <= busy;

            if (w_start_load)
                r_load_cnt <= '0;
            else if (w_load_beat)
                r_load_cnt <= r_load_cnt + 1'b1;

            if (w_start_dump) begin
                r_dump_sel <= dump_sel;
                r_ptr      <= '0;
            end else if (w_dump_end) begin
                r_ptr <= '0;
            end else if (w_dump_beat) begin
                r_ptr <= r_ptr + 1'b1;
            end

            if (r_state == ST_WAIT_BUSY)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            else
                r_wait_cnt <= 2'd0;

            if (w_start_load)
                r_err <= 1'b0;
            else if (w_timeout || w_wr_err || w_bad_dump)
                r_err <= 1'b1;
        end
    end

    // Arrays are never reset; a write coinciding with reset is suppressed.
    always_ff @(posedge clk) begin
        if (!reset && w_load_beat)
            r_img[r_load_cnt] <= load_data;
        if (!reset && w_wr_ok) begin
            case (csel)
                3'd1:    r_bank1[caddr_wr] <= cdata_wr;
                3'd2:    r_bank2[caddr_wr] <= cdata_wr;
                3'd3:    r_bank3[caddr_wr[c_L1_AW-1:0]] <= cdata_wr;
                3'd4:    r_bank4[caddr_wr[c_L1_AW-1:0]] <= cdata_wr;
                3'd5:    r_bank5[caddr_wr[c_L2_AW-1:0]] <= cdata_wr;
                default: ;
            endcase
        end
    end

    always_comb begin
        cdata_rd = '0;
        if (w_rd_ok) begin
            case (csel)
                3'd1:    cdata_rd = r_bank1[caddr_rd];
                3'd2:    cdata_rd = r_bank2[caddr_rd];
                3'd3:    cdata_rd = r_bank3[caddr_rd[c_L1_AW-1:0]];
                3'd4:    cdata_rd = r_bank4[caddr_rd[c_L1_AW-1:0]];
                3'd5:    cdata_rd = r_bank5[caddr_rd[c_L2_AW-1:0]];
                default: cdata_rd = '0;
            endcase
        end
    end

    always_comb begin
        case (r_dump_sel)
            3'd1:    dump_data = r_bank1[r_ptr];
            3'd2:    dump_data = r_bank2[r_ptr];
            3'd3:    dump_data = r_bank3[r_ptr[c_L1_AW-1:0]];
            3'd4:    dump_data = r_bank4[r_ptr[c_L1_AW-1:0]];
            3'd5:    dump_data = r_bank5[r_ptr[c_L2_AW-1:0]];
            default: dump_data = '0;
        endcase
    end

    assign idata      = r_img[iaddr];
    assign load_ready = (r_state == ST_LOAD);
    assign ready      = (r_state == ST_ARM);
    assign dump_valid = (r_state == ST_DUMP);
    assign dump_last  = (r_state == ST_DUMP) && (r_ptr == w_dump_last_idx);
    assign done       = (r_state == ST_RUN) && w_busy_fall;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_host_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_host_mem
// Purpose  : Randomized self-checking bench for conv_host_mem with a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_host_mem;
    localparam int DW = 20;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start, load_valid, load_ready;
    logic [DW-1:0] load_data;
    logic          dump_req, dump_valid, dump_last, dump_ready;
    logic [2:0]    dump_sel;
    logic [DW-1:0] dump_data;
    logic          done, err, ready, busy;
    logic [AW-1:0] iaddr, caddr_wr, caddr_rd;
    logic [DW-1:0] idata, cdata_wr, cdata_rd;
    logic          cwr, crd;
    logic [2:0]    csel;

    conv_host_mem dut (
        .clk(clk), .reset(reset),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready),
        .dump_req(dump_req), .dump_sel(dump_sel), .dump_valid(dump_valid),
        .dump_data(dump_data), .dump_last(dump_last), .dump_ready(dump_ready),
        .done(done), .err(err), .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .csel(csel)
    );

    always #5 clk = ~clk;

    // Reference memories: image plus banks 1..5, with a written-yet flag per word.
    logic [DW-1:0] m_img  [4096];
    logic [DW-1:0] m_bank [6][4096];
    bit            m_known[6][4096];

    int n_total = 0;
    int n_bad   = 0;
    int n_done  = 0;
    int n_ready = 0;

    always @(negedge clk) begin
        if (done)  n_done  = n_done + 1;
        if (ready) n_ready = n_ready + 1;
    end

    function automatic int depth_of(input int sel);
        case (sel)
            1, 2:    return 4096;
            3, 4:    return 1024;
            5:       return 2048;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int limit, input bit rnd_data, input bit gaps);
        int beats = 0;
        int cyc   = 0;
        logic [31:0] v;
        load_start = 1'b1;
        step;
        load_start = 1'b0;
        while (beats < limit && cyc < 20000) begin
            load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            v          = rnd_data ? $urandom : 32'(beats);
            load_data  = v[DW-1:0];
            #1;
            if (load_valid && load_ready) begin
                m_img[beats] = load_data;
                beats++;
            end
            step;
            cyc++;
        end
        load_valid = 1'b0;
        if (cyc >= 20000) check("load_bound", 32'(beats), 32'(limit));
    endtask

    task automatic lwr(input int sel, input int addr, input logic [DW-1:0] d);
        cwr = 1'b1; csel = 3'(sel); caddr_wr = AW'(addr); cdata_wr = d;
        step;
        cwr = 1'b0;
        if (depth_of(sel) > 0 && addr < depth_of(sel)) begin
            m_bank[sel][addr]  = d;
            m_known[sel][addr] = 1'b1;
        end
    endtask

    task automatic lrd(input bit rd, input int sel, input int addr, input string tag);
        logic [DW-1:0] exp;
        bit            known;
        crd = rd; csel = 3'(sel); caddr_rd = AW'(addr);
        #1;
        known = 1'b1;
        if (!rd || depth_of(sel) == 0 || addr >= depth_of(sel)) exp = '0;
        else begin
            exp   = m_bank[sel][addr];
            known = m_known[sel][addr];
        end
        if (known) check(tag, 32'(cdata_rd), 32'(exp));
        step;
        crd = 1'b0;
    endtask

    task automatic do_dump(input int sel, input bit rnd_ready);
        int beat  = 0;
        int cyc   = 0;
        int depth = depth_of(sel);
        bit tog   = 1'b0;
        dump_sel = 3'(sel); dump_req = 1'b1;
        step;
        dump_req = 1'b0;
        while (beat < depth && cyc < 10000) begin
            dump_ready = rnd_ready ? 1'($urandom_range(0, 1)) : tog;
            tog = ~tog;
            #1;
            check("dump_valid", 32'(dump_valid), 32'd1);
            if (m_known[sel][beat]) check("dump_data", 32'(dump_data), 32'(m_bank[sel][beat]));
            check("dump_last", 32'(dump_last), 32'(beat == depth - 1));
            if (dump_ready) beat++;
            step;
            cyc++;
        end
        dump_ready = 1'b0;
        if (cyc >= 10000) check("dump_bound", 32'(beat), 32'(depth));
        #1;
        check("dump_end_idle", 32'(dump_valid), 32'd0);
        step;
    endtask

    initial begin
        logic [DW-1:0] d;
        int a, s, done_base;
        reset = 1'b1; load_start = 0; load_valid = 0; load_data = '0;
        dump_req = 0; dump_sel = '0; dump_ready = 0; busy = 0;
        iaddr = '0; cwr = 0; caddr_wr = '0; cdata_wr = '0; crd = 0; caddr_rd = '0; csel = '0;
        repeat (3) step;
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_ready",      32'(ready),      32'd0);
        check("rst_dump_valid", 32'(dump_valid), 32'd0);
        check("rst_dump_last",  32'(dump_last),  32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_err",        32'(err),        32'd0);
        reset = 1'b0;

        // Aborted load: reset after 100 beats
        do_load(100, 1'b1, 1'b1);
        reset = 1'b1;
        step;
        check("abort_load_ready", 32'(load_ready), 32'd0);
        reset = 1'b0;

        // Full load with image[i] = i
        do_load(4096, 1'b0, 1'b1);
        check("arm_ready", 32'(ready), 32'd1);
        check("arm_load_ready", 32'(load_ready), 32'd0);
        busy = 1'b1;
        step;
        check("wait_ready_low", 32'(ready), 32'd0);
        step;
        check("ready_pulses", 32'(n_ready), 32'd1);
        check("run_err", 32'(err), 32'd0);

        iaddr = 12'hFFF; #1;
        check("idata_fff", 32'(idata), 32'h00FFF);
        step;
        for (int i = 0; i < 16; i++) begin
            iaddr = AW'($urandom_range(0, 4095)); #1;
            check("idata_rnd", 32'(idata), 32'(m_img[iaddr]));
            step;
        end

        for (int i = 0; i < 2048; i++) lwr(5, i, DW'($urandom));
        for (int i = 0; i < 10; i++) lwr(3, i, DW'($urandom));
        for (int i = 0; i < 150; i++) begin
            s = $urandom_range(1, 5);
            a = $urandom_range(0, depth_of(s) - 1);
            lwr(s, a, DW'($urandom));
            lrd(1'b1, s, a, "rd_after_wr");
        end
        check("run_err_clean", 32'(err), 32'd0);

        lwr(3, 1023, 20'h12345);
        lrd(1'b1, 3, 1023, "rd_3_1023");
        // Same-cycle read and write of one location
        cwr = 1'b1; csel = 3'd3; caddr_wr = 12'd1023; cdata_wr = 20'h54321;
        crd = 1'b1; caddr_rd = 12'd1023; #1;
        check("rw_old", 32'(cdata_rd), 32'h12345);
        step;
        cwr = 1'b0; crd = 1'b0;
        m_bank[3][1023] = 20'h54321;
        lrd(1'b1, 3, 1023, "rw_new");
        lrd(1'b0, 3, 1023, "crd_low_zero");
        lrd(1'b1, 0, 5, "csel0_zero");
        lrd(1'b1, 3, 1500, "oob_rd_zero");

        lwr(3, 1024, 20'h0ABCD);
        check("oob_wr_err", 32'(err), 32'd1);
        lrd(1'b1, 3, 0, "oob_wr_no_alias");

        busy = 1'b0; #1;
        check("done_pulse", 32'(done), 32'd1);
        step;
        check("done_one_cycle", 32'(done), 32'd0);
        check("done_count", 32'(n_done), 32'd1);

        do_dump(5, 1'b0);
        do_dump(3, 1'b1);

        // Writes outside ARM/WAIT_BUSY/RUN are ignored
        lwr(6, 0, '0);
        m_bank[3][5] = m_bank[3][5];
        cwr = 1'b1; csel = 3'd3; caddr_wr = 12'd5; cdata_wr = ~m_bank[3][5];
        step;
        cwr = 1'b0;
        lrd(1'b1, 3, 5, "idle_wr_ignored");

        reset = 1'b1;
        step;
        reset = 1'b0;
        check("reset_err_clear", 32'(err), 32'd0);
        iaddr = 12'd777; #1;
        check("img_persist", 32'(idata), 32'(m_img[777]));
        step;
        dump_sel = 3'd7; dump_req = 1'b1;
        step;
        dump_req = 1'b0;
        check("bad_dump_err", 32'(err), 32'd1);
        check("bad_dump_idle", 32'(dump_valid), 32'd0);

        // Start timeout: busy never rises
        done_base = n_done;
        do_load(4096, 1'b1, 1'b0);
        check("to_arm", 32'(ready), 32'd1);
        check("to_err_cleared", 32'(err), 32'd0);
        repeat (3) step;
        check("to_err_early", 32'(err), 32'd0);
        repeat (2) step;
        check("to_err", 32'(err), 32'd1);
        check("to_no_done", 32'(n_done), 32'(done_base));
        check("to_idle_ready", 32'(ready), 32'd0);
        for (int i = 0; i < 8; i++) begin
            iaddr = AW'($urandom_range(0, 4095)); #1;
            check("idata_reload", 32'(idata), 32'(m_img[iaddr]));
            step;
        end

        // Invalid csel write during a run
        do_load(4096, 1'b1, 1'b0);
        busy = 1'b1;
        repeat (2) step;
        check("run2_err", 32'(err), 32'd0);
        lwr(6, 0, 20'hFFFFF);
        check("csel6_err", 32'(err), 32'd1);
        for (int b = 1; b <= 5; b++) lrd(1'b1, b, 0, "csel6_no_change");
        busy = 1'b0; #1;
        check("done2_pulse", 32'(done), 32'd1);
        step;
        check("done2_count", 32'(n_done), 32'(done_base + 1));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end
endmodule
`default_nettype wire
